// File: rtl/path_loader.sv
// Path bus transmitter: packs a valid/ready stream of node IDs into a padded flat bus and
// presents it with a valid/ack handshake. Optional ID checking is enabled by PATH_CHECK_EN.
module path_loader #(
   parameter int                NODE_W    = 7,
   parameter int                MAX_NODES = 36,
   parameter logic [NODE_W-1:0] PAD_ID    = 7'h7F,
   parameter int                NUM_NODES = 40
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NODE_W-1:0]             node_in,
   input  logic                          node_valid,
   input  logic                          node_last,
   output logic                          node_ready,
   input  logic                          path_abort,
   output logic [NODE_W*MAX_NODES-1:0]   path,
   output logic [NODE_W-1:0]             s,
   output logic [NODE_W-1:0]             e,
   output logic [$clog2(MAX_NODES+1)-1:0] node_count,
   output logic                          path_valid,
   input  logic                          path_ack,
   output logic                          path_err
);

   localparam int CNT_W = $clog2(MAX_NODES + 1);
   localparam logic [NODE_W*MAX_NODES-1:0] PAD_PATH = {MAX_NODES{PAD_ID}};
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_NODES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Handshakes: a node transfers on a rising edge where node_valid and node_ready are both 1;
   // a path transfers on a rising edge where path_valid and path_ack are both 1.
   logic [1:0]                  state;
   logic                        ready_en;
   logic [NODE_W*MAX_NODES-1:0] path_q;
   logic [NODE_W-1:0]           s_q;
   logic [NODE_W-1:0]           e_q;
   logic [NODE_W-1:0]           prev_node;
   logic [CNT_W-1:0]            count_q;

   logic accept;
   logic node_ok;
   logic store;
   logic finish;
   logic drop_last;

`ifdef PATH_CHECK_EN
   localparam logic [NODE_W-1:0] NUM_ID = NODE_W'(NUM_NODES);
   logic err_q;
   assign node_ok  = (node_in < NUM_ID) && (node_in != PAD_ID);
   assign path_err = err_q;
`else
   assign node_ok  = 1'b1;
   assign path_err = 1'b0;
`endif

   assign node_ready = ready_en && (state != DONE);
   assign accept     = node_valid && node_ready;
   assign store      = accept && node_ok && !path_abort;
   assign finish     = store && (node_last || (count_q == LAST_SLOT));
   // A rejected final node still closes the path if at least one good node is held.
   assign drop_last  = accept && !node_ok && node_last && !path_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         path_q    <= PAD_PATH;
         s_q       <= '0;
         e_q       <= '0;
         prev_node <= '0;
         count_q   <= '0;
      end else if (state != DONE) begin
         if (path_abort) begin
            state   <= IDLE;
            path_q  <= PAD_PATH;
            count_q <= '0;
         end else if (store) begin
            for (int k = 0; k < MAX_NODES; k++) begin
               if (count_q == CNT_W'(k)) begin
                  path_q[k*NODE_W +: NODE_W] <= node_in;
               end
            end
            count_q   <= count_q + 1'b1;
            prev_node <= node_in;
            if (state == IDLE) begin
               s_q <= node_in;
            end
            if (finish) begin
               e_q   <= node_in;
               state <= DONE;
            end else begin
               state <= LOAD;
            end
         end else if (drop_last && (state == LOAD)) begin
            e_q   <= prev_node;
            state <= DONE;
         end
      end else if (path_ack) begin
         state   <= IDLE;
         path_q  <= PAD_PATH;
         count_q <= '0;
      end
   end

`ifdef PATH_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state == DONE) && path_ack) begin
         err_q <= 1'b0;
      end else if (accept && !node_ok) begin
         err_q <= 1'b1;
      end
   end
`endif

   assign path       = path_q;
   assign s          = s_q;
   assign e          = e_q;
   assign node_count = count_q;
   assign path_valid = (state == DONE);

endmodule

// File: tb/tb_path_loader.sv
// Bench for path_loader: directed scenarios plus random paths checked against a queue model.
module tb_path_loader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [6:0]   node_in = '0;
   logic         node_valid = 1'b0;
   logic         node_last = 1'b0;
   logic         node_ready;
   logic         path_abort = 1'b0;
   logic [251:0] path;
   logic [6:0]   s;
   logic [6:0]   e;
   logic [5:0]   node_count;
   logic         path_valid;
   logic         path_ack = 1'b0;
   logic         path_err;

   int total = 0;
   int bad = 0;

   logic [6:0] model_q[$];
   logic [6:0] exp_s = '0;
   logic [6:0] exp_e = '0;
   logic       exp_err = 1'b0;

   always #5 clk = ~clk;

   path_loader dut (
      .clk(clk), .rst(rst), .node_in(node_in), .node_valid(node_valid),
      .node_last(node_last), .node_ready(node_ready), .path_abort(path_abort),
      .path(path), .s(s), .e(e), .node_count(node_count), .path_valid(path_valid),
      .path_ack(path_ack), .path_err(path_err)
   );

   function automatic logic [251:0] model_path();
      logic [251:0] p;
      p = {36{7'h7F}};
      for (int i = 0; i < model_q.size(); i++) p[i*7 +: 7] = model_q[i];
      return p;
   endfunction

   function automatic bit legal(input logic [6:0] id);
`ifdef PATH_CHECK_EN
      return (id < 7'd40) && (id != 7'h7F);
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [251:0] obs, input logic [251:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge after the node is taken.
   task automatic send_node(input logic [6:0] id, input bit last);
      bit ok;
      ok = 1'b0;
      node_in = id;
      node_valid = 1'b1;
      node_last = last;
      for (int c = 0; c < 50 && !ok; c++) begin
         if (node_ready === 1'b1) ok = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      node_valid = 1'b0;
      node_last = 1'b0;
      chk("accept", ok, 1'b1);
      if (ok) begin
         if (legal(id)) model_q.push_back(id);
         else exp_err = 1'b1;
      end
   endtask

   task automatic check_done(input string tag);
      exp_s = model_q[0];
      exp_e = model_q[model_q.size()-1];
      chk({tag, "_valid"}, path_valid, 1'b1);
      chk({tag, "_path"}, path, model_path());
      chk({tag, "_s"}, s, exp_s);
      chk({tag, "_e"}, e, exp_e);
      chk({tag, "_count"}, node_count, model_q.size());
      chk({tag, "_ready"}, node_ready, 1'b0);
      chk({tag, "_err"}, path_err, exp_err);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, path_valid, 1'b0);
      chk({tag, "_path"}, path, {36{7'h7F}});
      chk({tag, "_count"}, node_count, 6'd0);
      chk({tag, "_ready"}, node_ready, 1'b1);
   endtask

   task automatic do_ack(input string tag);
      path_ack = 1'b1;
      @(negedge clk);
      path_ack = 1'b0;
      model_q.delete();
      exp_err = 1'b0;
      check_idle(tag);
      chk({tag, "_s_kept"}, s, exp_s);
      chk({tag, "_e_kept"}, e, exp_e);
      chk({tag, "_err"}, path_err, 1'b0);
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      chk("rst_path", path, {36{7'h7F}});
      chk("rst_s", s, 7'd0);
      chk("rst_e", e, 7'd0);
      chk("rst_count", node_count, 6'd0);
      chk("rst_valid", path_valid, 1'b0);
      chk("rst_err", path_err, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", node_ready, 1'b1);

      // three-node path, valid one clock after final accept
      send_node(7'd33, 1'b0);
      send_node(7'd12, 1'b0);
      send_node(7'd3, 1'b1);
      check_done("t1");
      do_ack("t1_ack");

      // single node, long hold, abort in DONE is ignored
      send_node(7'd5, 1'b1);
      check_done("t2");
      for (int i = 0; i < 20; i++) begin
         if (i == 10) path_abort = 1'b1;
         if (i == 12) node_valid = 1'b1;
         @(negedge clk);
         chk("t2_hold_valid", path_valid, 1'b1);
         chk("t2_hold_ready", node_ready, 1'b0);
         chk("t2_hold_path", path, model_path());
      end
      path_abort = 1'b0;
      node_valid = 1'b0;
      chk("t2_hold_count", node_count, 6'd1);
      do_ack("t2_ack");

      // overflow truncation at 36 nodes
      for (int i = 0; i < 36; i++) send_node(7'(i), 1'b0);
      check_done("t3");
      node_in = 7'd36;
      node_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_no_accept_ready", node_ready, 1'b0);
      end
      node_valid = 1'b0;
      chk("t3_count_sat", node_count, 6'd36);
      chk("t3_e", e, 7'd35);
      do_ack("t3_ack");

      // abort outranks a simultaneous accept
      send_node(7'd7, 1'b0);
      send_node(7'd8, 1'b0);
      node_in = 7'd9;
      node_valid = 1'b1;
      path_abort = 1'b1;
      @(negedge clk);
      node_valid = 1'b0;
      path_abort = 1'b0;
      model_q.delete();
      check_idle("t4");
      repeat (5) @(negedge clk);
      chk("t4_no_valid", path_valid, 1'b0);

      // asynchronous reset mid-load
      send_node(7'd1, 1'b0);
      send_node(7'd2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t5_path", path, {36{7'h7F}});
      chk("t5_count", node_count, 6'd0);
      chk("t5_valid", path_valid, 1'b0);
      chk("t5_s", s, 7'd0);
      chk("t5_e", e, 7'd0);
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      chk("t5_ready", node_ready, 1'b1);
      send_node(7'd10, 1'b0);
      send_node(7'd11, 1'b1);
      check_done("t5_fresh");
      do_ack("t5_ack");

      // random paths
      for (int p = 0; p < 8; p++) begin
         int len;
         len = $urandom_range(1, 36);
         for (int i = 0; i < len; i++) begin
            bit last;
            last = (i == len - 1) && ((len < 36) || ($urandom_range(0, 1) == 1));
            send_node(7'($urandom_range(0, 39)), last);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         check_done("rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rnd_hold_path", path, model_path());
         do_ack("rnd_ack");
      end

`ifdef PATH_CHECK_EN
      // illegal IDs are dropped and flagged
      send_node(7'd4, 1'b0);
      send_node(7'd45, 1'b0);
      send_node(7'd6, 1'b1);
      check_done("t6");
      chk("t6_err", path_err, 1'b1);
      do_ack("t6_ack");
      send_node(7'd50, 1'b1);
      @(negedge clk);
      check_idle("t6_drop_only");
      chk("t6_drop_err", path_err, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
